// File: rtl/ram_loader_module_pkg.sv
// ram_loader_module_pkg
//   Shared types for the program loader: FSM state encoding, the bundle of
//   state-decoded output strobes, and the decode function that maps a state
//   onto those strobes.
`timescale 1ns/1ps
package ram_loader_module_pkg;

    localparam int DEFAULT_MEM_DEPTH  = 16;
    localparam int DEFAULT_RST_CYCLES = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_WAIT,
        S_ADDR,
        S_WRITE,
        S_RELEASE
    } state_t;

    // Control outputs that depend only on the state.
    typedef struct packed {
        logic in_ready;
        logic halt;
        logic busy;
        logic bus_oe;
        logic mai;
        logic mi;
        logic cpu_rst_n;
    } strobes_t;

    function automatic strobes_t decode(input state_t s);
        strobes_t o;
        o           = '0;
        o.cpu_rst_n = 1'b1;
        case (s)
            S_HALT:    begin o.halt = 1'b1; o.busy = 1'b1; end
            S_WAIT:    begin o.halt = 1'b1; o.busy = 1'b1; o.in_ready = 1'b1; end
            S_ADDR:    begin o.halt = 1'b1; o.busy = 1'b1; o.bus_oe = 1'b1; o.mai = 1'b1; end
            S_WRITE:   begin o.halt = 1'b1; o.busy = 1'b1; o.bus_oe = 1'b1; o.mi = 1'b1; end
            S_RELEASE: begin o.halt = 1'b1; o.busy = 1'b1; o.cpu_rst_n = 1'b0; end
            default:   ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/ram_loader_module.sv
// ram_loader_module
//   Writes a program image into RAM while the CPU is halted. Bytes arrive on a
//   valid/ready stream; each one is written by presenting its address with
//   mai, then the byte with mi. After the last byte the CPU is released with a
//   cpu_rst_n pulse of RST_CYCLES cycles.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   load_req   start a load (sampled in IDLE only)
//   len        byte count; 0 or > MEM_DEPTH means MEM_DEPTH
//   in_data    stream byte
//   in_valid   stream byte valid
//   in_ready   loader accepts a byte this cycle
//   halt       CPU clock gate request
//   cpu_rst_n  active-low CPU reset pulse
//   bus_oe     loader drives the shared bus
//   bus_data   value driven on the bus
//   mai        memory address register load strobe
//   mi         RAM write strobe
//   busy       high in every state except IDLE
//   done       one-cycle completion pulse
//   count      bytes written in the current or last load
`timescale 1ns/1ps
module ram_loader_module
    import ram_loader_module_pkg::*;
#(
    parameter int MEM_DEPTH  = DEFAULT_MEM_DEPTH,
    parameter int RST_CYCLES = DEFAULT_RST_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_req,
    input  logic [7:0] len,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       halt,
    output logic       cpu_rst_n,
    output logic       bus_oe,
    output logic [7:0] bus_data,
    output logic       mai,
    output logic       mi,
    output logic       busy,
    output logic       done,
    output logic [7:0] count
);

    localparam logic [8:0]  DEPTH    = 9'(MEM_DEPTH);
    localparam logic [15:0] REL_LAST = 16'(RST_CYCLES - 1);

    state_t      state;
    strobes_t    strb;
    logic [8:0]  cnt;       // 9 bits so a full 256-word load can be counted
    logic [8:0]  len_q;
    logic [7:0]  byte_q;
    logic [7:0]  bus_data_q;
    logic        done_q;
    logic [15:0] rel_cnt;

    // NOTE: every output register is loaded on the same edge as the state it
    // belongs to, so outputs are registered yet line up with the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            strb       <= decode(S_IDLE);
            cnt        <= '0;
            len_q      <= '0;
            byte_q     <= '0;
            bus_data_q <= '0;
            done_q     <= 1'b0;
            rel_cnt    <= '0;
        end else begin
            done_q     <= 1'b0;
            bus_data_q <= '0;
            case (state)
                S_IDLE: begin
                    if (load_req) begin
                        state <= S_HALT;
                        strb  <= decode(S_HALT);
                        cnt   <= '0;
                        // Zero and oversize lengths both mean "fill the RAM",
                        // which also guarantees the address never wraps.
                        if (len == 8'd0 || {1'b0, len} > DEPTH)
                            len_q <= DEPTH;
                        else
                            len_q <= {1'b0, len};
                    end
                end
                S_HALT: begin
                    state <= S_WAIT;
                    strb  <= decode(S_WAIT);
                end
                S_WAIT: begin
                    // in_ready is high for the whole of WAIT.
                    if (in_valid) begin
                        byte_q     <= in_data;
                        bus_data_q <= cnt[7:0];
                        state      <= S_ADDR;
                        strb       <= decode(S_ADDR);
                    end
                end
                S_ADDR: begin
                    bus_data_q <= byte_q;
                    state      <= S_WRITE;
                    strb       <= decode(S_WRITE);
                end
                S_WRITE: begin
                    cnt <= cnt + 9'd1;
                    if (cnt + 9'd1 == len_q) begin
                        rel_cnt <= '0;
                        state   <= S_RELEASE;
                        strb    <= decode(S_RELEASE);
                    end else begin
                        state <= S_WAIT;
                        strb  <= decode(S_WAIT);
                    end
                end
                S_RELEASE: begin
                    if (rel_cnt == REL_LAST) begin
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                        strb   <= decode(S_IDLE);
                    end else begin
                        rel_cnt <= rel_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    strb  <= decode(S_IDLE);
                end
            endcase
        end
    end

    assign in_ready  = strb.in_ready;
    assign halt      = strb.halt;
    assign busy      = strb.busy;
    assign bus_oe    = strb.bus_oe;
    assign mai       = strb.mai;
    assign mi        = strb.mi;
    assign cpu_rst_n = strb.cpu_rst_n;
    assign bus_data  = bus_data_q;
    assign done      = done_q;
    assign count     = cnt[7:0];

endmodule

// File: tb/tb_ram_loader_module.sv
`timescale 1ns/1ps
module tb_ram_loader_module;

    localparam int DEPTH = 16;
    localparam int RSTC  = 2;

    logic       clk = 1'b0;
    logic       rst, load_req, in_valid;
    logic [7:0] len, in_data, bus_data, count;
    logic       in_ready, halt, cpu_rst_n, bus_oe, mai, mi, busy, done;

    always #5 clk = ~clk;

    ram_loader_module #(.MEM_DEPTH(DEPTH), .RST_CYCLES(RSTC)) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .len(len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .halt(halt), .cpu_rst_n(cpu_rst_n), .bus_oe(bus_oe),
        .bus_data(bus_data), .mai(mai), .mi(mi), .busy(busy),
        .done(done), .count(count)
    );

    int         tests = 0;
    int         fails = 0;
    logic [7:0] src [256];
    int         src_idx;
    int         gap_max;
    logic [7:0] wr_addr [$];
    logic [7:0] wr_data [$];
    logic [7:0] last_addr;
    bit         have_addr;

    typedef struct {
        logic [7:0] len;
        int         eff;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Effective length from the loader's rules: 0 or oversize fills the RAM.
    function automatic int ref_eff(input int l);
        if (l == 0 || l > DEPTH) return DEPTH;
        return l;
    endfunction

    // Bus observer: records every (mai address, mi data) pair and checks
    // bus ownership rules on each strobe cycle.
    initial begin
        have_addr = 1'b0;
        last_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                have_addr = 1'b0;
            end else begin
                if (bus_oe) check("oe_implies_halt", {31'd0, halt}, 32'd1);
                if (mai || mi) check("mai_mi_exclusive", {31'd0, mai & mi}, 32'd0);
                if (mai) begin
                    last_addr = bus_data;
                    have_addr = 1'b1;
                end
                if (mi) begin
                    check("mi_after_mai", {31'd0, have_addr}, 32'd1);
                    wr_addr.push_back(last_addr);
                    wr_data.push_back(bus_data);
                    have_addr = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic next_valid();
        in_valid = (gap_max == 0) ? 1'b1 : ($urandom_range(0, gap_max) == 0);
        in_data  = src[src_idx & 255];
    endtask

    // Runs the stream until done (or the cycle budget runs out).
    task automatic drain(output int cycles, output int rst_low, output bit got_done);
        bit acc;
        cycles = 0; rst_low = 0; got_done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            acc = in_valid && in_ready;
            step();
            cycles++;
            if (acc) src_idx++;
            if (!cpu_rst_n) rst_low++;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            next_valid();
        end
        in_valid = 1'b0;
    endtask

    task automatic check_writes(input int eff);
        check("n_writes", wr_addr.size(), eff);
        for (int i = 0; i < wr_addr.size() && i < eff; i++) begin
            check("wr_addr", {24'd0, wr_addr[i]}, i);
            check("wr_data", {24'd0, wr_data[i]}, {24'd0, src[i]});
        end
    endtask

    task automatic run_load(input logic [7:0] l, input int gm, input bit fixed_src);
        int eff, cyc, rl;
        bit gd;
        eff     = ref_eff(int'(l));
        gap_max = gm;
        if (!fixed_src) for (int i = 0; i < 256; i++) src[i] = 8'($urandom);
        wr_addr.delete(); wr_data.delete();
        src_idx  = 0;
        load_req = 1'b1;
        len      = l;
        next_valid();
        step();
        load_req = 1'b0;
        check("busy_after_req", {31'd0, busy}, 32'd1);
        check("halt_after_req", {31'd0, halt}, 32'd1);
        check("ready_low_in_halt", {31'd0, in_ready}, 32'd0);
        drain(cyc, rl, gd);
        check("done_seen", {31'd0, gd}, 32'd1);
        check("release_len", rl, RSTC);
        if (gm == 0) check("load_cycles", cyc + 1, 2 + 3 * eff + RSTC);
        check("count_final", {24'd0, count}, eff);
        check("halt_off_at_done", {31'd0, halt}, 32'd0);
        check("cpu_rst_hi_at_done", {31'd0, cpu_rst_n}, 32'd1);
        step();
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check_writes(eff);
    endtask

    initial begin
        int cyc, rl, mis;
        bit gd, acc;

        vecs[0] = '{8'd3,  3};
        vecs[1] = '{8'd0,  16};
        vecs[2] = '{8'd40, 16};
        vecs[3] = '{8'd16, 16};
        vecs[4] = '{8'd1,  1};
        vecs[5] = '{8'd17, 16};
        vecs[6] = '{8'd15, 15};

        // Reset and idle
        rst = 1'b0; load_req = 1'b0; in_valid = 1'b0; len = '0; in_data = '0; gap_max = 0;
        step(); step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_halt", {31'd0, halt}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_bus_oe", {31'd0, bus_oe}, 32'd0);
        check("rst_mai", {31'd0, mai}, 32'd0);
        check("rst_mi", {31'd0, mi}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_count", {24'd0, count}, 32'd0);
        check("rst_bus_data", {24'd0, bus_data}, 32'd0);
        check("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        rst = 1'b1;
        step();
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Three-byte load with the documented image
        src[0] = 8'h1E; src[1] = 8'h2F; src[2] = 8'hE0;
        run_load(8'd3, 0, 1'b1);
        if (wr_data.size() == 3) begin
            check("img_byte0", {24'd0, wr_data[0]}, 32'h1E);
            check("img_byte1", {24'd0, wr_data[1]}, 32'h2F);
            check("img_byte2", {24'd0, wr_data[2]}, 32'hE0);
        end

        // Length table, back-to-back stream
        for (int v = 0; v < 7; v++) begin
            run_load(vecs[v].len, 0, 1'b0);
            check("table_count", {24'd0, count}, vecs[v].eff);
        end

        // Backpressure, then load_req pulsed during WRITE
        gap_max = 0;
        for (int i = 0; i < 256; i++) src[i] = 8'($urandom);
        wr_addr.delete(); wr_data.delete(); src_idx = 0;
        load_req = 1'b1; len = 8'd3; in_valid = 1'b0;
        step(); load_req = 1'b0;
        step();
        check("ready_in_wait", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_ready", {31'd0, in_ready}, 32'd1);
            check("bp_no_strobe", {29'd0, mai, mi, bus_oe}, 32'd0);
        end
        in_valid = 1'b1; in_data = src[0];
        step(); src_idx = 1; in_valid = 1'b0;
        check("bp_mai", {31'd0, mai}, 32'd1);
        check("bp_addr", {24'd0, bus_data}, 32'd0);
        check("bp_ready_low", {31'd0, in_ready}, 32'd0);
        step();
        check("bp_mi", {31'd0, mi}, 32'd1);
        check("bp_data", {24'd0, bus_data}, {24'd0, src[0]});
        load_req = 1'b1; len = 8'd9;
        step(); load_req = 1'b0;
        check("late_req_count", {24'd0, count}, 32'd1);
        check("late_req_wait", {31'd0, in_ready}, 32'd1);
        check("late_req_halt", {31'd0, halt}, 32'd1);
        next_valid();
        drain(cyc, rl, gd);
        check("bp_done", {31'd0, gd}, 32'd1);
        check("bp_count", {24'd0, count}, 32'd3);
        step();
        check_writes(3);

        // Reset in the cycle after the second mi
        for (int i = 0; i < 256; i++) src[i] = 8'($urandom);
        src_idx = 0; mis = 0;
        load_req = 1'b1; len = 8'd5; next_valid();
        step(); load_req = 1'b0;
        for (int i = 0; i < 100 && mis < 2; i++) begin
            acc = in_valid && in_ready;
            step();
            if (acc) src_idx++;
            if (mi) mis++;
            if (mis < 2) next_valid();
        end
        check("two_mi_seen", mis, 32'd2);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1; in_valid = 1'b0;
        check("midrst_halt", {31'd0, halt}, 32'd0);
        check("midrst_bus_oe", {31'd0, bus_oe}, 32'd0);
        check("midrst_count", {24'd0, count}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        step();
        run_load(8'd3, 0, 1'b0);

        // Random lengths with random valid gaps
        for (int k = 0; k < 6; k++)
            run_load(8'($urandom_range(0, 40)), $urandom_range(1, 3), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram_loader_module.md
# ram_loader_module

Program loader that sequences the shared 8-bit bus, memory address register and RAM to write a program image into memory while the CPU is halted. It accepts bytes over a valid/ready stream (switch panel or serial receiver), drives each byte and its address onto the bus with the `MAI`/`MI` strobes, then releases the CPU with a reset pulse. It sits beside `control_module`. Its strobes are OR'd into `ctrl[MAI]`/`ctrl[MI]`, and its `halt` output gates the CPU clock in `clock_module`.

## Interface
- `MEM_DEPTH`, 16: RAM words writable, 1..256.
- `RST_CYCLES`, 2: length of the `cpu_rst_n` low pulse after a load, ≥1.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `load_req` in 1: start a load; sampled in IDLE only.
- `len` in 8: byte count, latched on an accepted `load_req`.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader accepts a byte this cycle.
- `halt` out 1: CPU clock gate request.
- `cpu_rst_n` out 1: active-low CPU reset pulse.
- `bus_oe` out 1: loader drives the bus; external tri-state.
- `bus_data` out 8: value driven on the bus.
- `mai` out 1: memory address register load strobe.
- `mi` out 1: RAM write strobe.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: 1-cycle completion pulse.
- `count` out 8: bytes written in the current or last load.

## Operation
- **Reset values.** `rst` low sets state IDLE and every output to 0, except `cpu_rst_n`, which resets to 1. This applies mid-load as well: `halt` drops and partial RAM contents stay as written.
- **Length latch.** On `load_req` in IDLE, the effective length is latched:
  - `len`=0 latches as MEM_DEPTH.
  - `len`>MEM_DEPTH clamps to MEM_DEPTH.
- **Address.** The write address equals `count`, starting at 0. It never wraps, because of the clamp.
- **States.**
  - IDLE: on `load_req`, go to HALT, clear `count`, set `halt`=1.
  - HALT: one settle cycle for the clock gate, then WAIT.
  - WAIT: `in_ready`=1. On `in_valid`&&`in_ready`, register the byte and go to ADDR. Otherwise hold, with no timeout.
  - ADDR: `bus_oe`=1, `bus_data`=`count`, `mai`=1; go to WRITE.
  - WRITE: `bus_oe`=1, `bus_data`=the registered byte, `mi`=1; increment `count`. Go to RELEASE if the new `count` equals the latched length, else WAIT.
  - RELEASE: `cpu_rst_n`=0 for RST_CYCLES cycles with `halt` still 1, then go to IDLE.
- **Exit from RELEASE.** On the transition to IDLE, `halt`=0, `cpu_rst_n`=1, and `done` pulses for exactly one cycle.
- **Handshake.**
  - `in_ready` depends on state only, never combinationally on `in_valid`.
  - At most one byte is accepted per three cycles.
- **Ignored inputs.**
  - `load_req` while `busy`=1 is ignored.
  - `in_valid` outside WAIT is ignored and the byte is not consumed.
- **Bus ownership.** `bus_oe` is high only in ADDR and WRITE, so the bus is never driven while `halt`=0.

## Timing
- All outputs are registered, decoded from a registered state.
- `load_req` sampled at edge N gives `busy`=`halt`=1 from N+1 and `in_ready`=1 from N+2.
- A byte accepted at edge M gives:
  - `mai` during cycle M+1;
  - `mi` during cycle M+2;
  - `count` updated at edge M+3.
- Minimum total load time is 2 + 3·L + RST_CYCLES cycles for length L.
- `done` is high in the first IDLE cycle.

## Structure
- State encodings (IDLE, HALT, WAIT, ADDR, WRITE, RELEASE) and the MEM_DEPTH default go in `global.vh` next to the control signal indices.
- Top-level hookup, not part of this block:
  - `ctrl[MAI] | mai`;
  - `ctrl[MI] | mi`;
  - `clock_module` gated by `halt`;
  - CPU reset = `rst & cpu_rst_n`.
- Single module `ram_loader_module`; no sub-module is needed. The length clamp and counter stay inline.

## Test plan
- **Reset and idle.** `rst`=0 for 2 cycles, then 1 -> all outputs 0, `cpu_rst_n`=1, state IDLE.
- **Three-byte load.** `load_req` with `len`=3, bytes 0x1E, 0x2F, 0xE0 with `in_valid` always high ->
  - `mai`/`bus_data` = 0, 1, 2, each followed by `mi` with the matching byte;
  - `cpu_rst_n` low 2 cycles;
  - `done` pulse;
  - `count`=3;
  - total 13 cycles.
- **Length clamp.** `len`=0, then `len`=40, MEM_DEPTH=16 -> exactly 16 writes, addresses 0..15, `count`=16, no wrap to 0.
- **Backpressure and late load request.**
  - `in_valid` low for 5 cycles in WAIT -> loader holds with `in_ready`=1 and no strobes.
  - `load_req` pulsed during WRITE -> ignored, no restart.
- **Reset mid-load.** `rst` low in the cycle after the second `mi` -> next cycle `halt`=0, `bus_oe`=0, `count`=0, IDLE. A fresh load then succeeds.
- **Bus exclusivity.** Checker over random `in_valid` gaps -> `bus_oe` implies `halt`, `mai` and `mi` are never high together, and the `mi` address equals the prior `mai` value.
